uart_autobaud_detect: RTL

//  Inverse of the 16x baud tick generator: measures an incoming 0x55 sync character
//  (8N1, LSB first) on the serial RX line and derives the baud_val / baud_val_fraction

---
 rtl/uart_autobaud_detect_pkg.sv | 28 ++
 rtl/uart_autobaud_detect_rx_sync.sv | 39 +++
 rtl/uart_autobaud_detect.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_autobaud_detect_pkg.sv
`default_nettype none
//--------------------------------------------------------------------------
// Module   : uart_autobaud_detect_pkg
// Purpose  : Shared types and constants for the UART auto-baud detector.
// Revision : 1.0 - initial release
//--------------------------------------------------------------------------
package uart_autobaud_detect_pkg;

    // Detector states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_MEASURE    = 3'd2,
        ST_STOP_CHK   = 3'd3,
        ST_DONE       = 3'd4,
        ST_ERR        = 3'd5
    } state_t;

    // Sync character and its measurement geometry
    localparam logic [7:0] c_SYNC_CHAR      = 8'h55;
    localparam int         c_EDGES_PER_SYNC = 5;
    localparam int         c_TICKS_PER_MEAS = 128;
    localparam int         c_TICK_SHIFT     = $clog2(c_TICKS_PER_MEAS);
    localparam int         c_BAUD_VAL_MAX   = 8191;

endpackage

`default_nettype wire

// File: rtl/uart_autobaud_detect_rx_sync.sv
`default_nettype none
//--------------------------------------------------------------------------
// Module   : uart_autobaud_detect_rx_sync
// Purpose  : Metastability chain for the asynchronous RX line plus falling
//            and rising edge detection on the synchronized level.
// Revision : 1.0 - initial release
//--------------------------------------------------------------------------
module uart_autobaud_detect_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fe,
    output logic o_re
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_dly;

    // Shift the line through the sync chain; reset to idle-high so no false edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync   <= '1;
            r_rx_dly <= 1'b1;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_rx};
            r_rx_dly <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rx_s = r_sync[SYNC_STAGES-1];
    assign o_fe   =  r_rx_dly & ~r_sync[SYNC_STAGES-1];
    assign o_re   = ~r_rx_dly &  r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_autobaud_detect.sv
`default_nettype none
//--------------------------------------------------------------------------
// Module   : uart_autobaud_detect
// Purpose  : Measures an incoming 0x55 sync character and derives the
//            baud_val / baud_val_fraction pair for the 16x tick generator.
// Revision : 1.0 - initial release
//--------------------------------------------------------------------------
module uart_autobaud_detect
    import uart_autobaud_detect_pkg::*;
#(
    parameter int BAUD_VAL_FRCTN_EN = 0,
    parameter int SYNC_STAGES       = 2,
    parameter int CNT_W             = 21,
    parameter int TOL_SHIFT         = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        rx,
    output logic [12:0] baud_val,
    output logic [2:0]  baud_val_fraction,
    output logic        locked,
    output logic        busy,
    output logic        detect_err
);

    logic w_rx_s, w_fe, w_re;

    uart_autobaud_detect_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_rx    (rx),
        .o_rx_s  (w_rx_s),
        .o_fe    (w_fe),
        .o_re    (w_re)
    );

    state_t             r_state,     w_state_nxt;
    logic [CNT_W-1:0]   r_t,         w_t_nxt;
    logic [CNT_W-1:0]   r_seg,       w_seg_nxt;
    logic [CNT_W-1:0]   r_i1,        w_i1_nxt;
    logic [2:0]         r_edge_cnt,  w_edge_cnt_nxt;
    logic               r_stop_ph,   w_stop_ph_nxt;
    logic [12:0]        r_baud_val,  w_baud_val_nxt;
    logic [2:0]         r_frac,      w_frac_nxt;
    logic               r_locked,    w_locked_nxt;
    logic               r_busy,      w_busy_nxt;
    logic               r_err,       w_err_nxt;

    // Interval arithmetic shared by the measurement and stop checks
    logic [CNT_W-1:0] w_t_inc, w_seg_inc, w_diff, w_tol, w_half, w_stop_lim;
    logic             w_tol_fail;
    assign w_t_inc    = r_t + 1'b1;
    assign w_seg_inc  = r_seg + 1'b1;
    assign w_diff     = (w_seg_inc >= r_i1) ? (w_seg_inc - r_i1) : (r_i1 - w_seg_inc);
    assign w_tol      = r_i1 >> TOL_SHIFT;
    assign w_half     = r_i1 >> 1;
    assign w_stop_lim = w_half + w_tol;
    assign w_tol_fail = (w_diff > w_tol);

    // Result: T spans 8 bits = 128 ticks, so T/128 is the tick period
    logic [CNT_W-1:0] w_quot;
    logic             w_round;
    logic [31:0]      w_raw;
    logic             w_range_ok;
    logic [12:0]      w_bv;
    logic [2:0]       w_frac_calc;
    assign w_quot      = r_t >> c_TICK_SHIFT;
    assign w_round     = (BAUD_VAL_FRCTN_EN == 0) ? r_t[c_TICK_SHIFT-1] : 1'b0;
    assign w_raw       = 32'(w_quot) + 32'(w_round);
    assign w_range_ok  = (w_quot != '0) && (w_raw <= 32'(c_BAUD_VAL_MAX + 1));
    assign w_bv        = w_raw[12:0] - 13'd1;
    assign w_frac_calc = (BAUD_VAL_FRCTN_EN != 0) ? 3'(r_t >> (c_TICK_SHIFT - 3)) : 3'd0;

    // Next-state and next-output computation for the hunt/measure FSM
    always_comb begin
        w_state_nxt    = r_state;
        w_t_nxt        = r_t;
        w_seg_nxt      = r_seg;
        w_i1_nxt       = r_i1;
        w_edge_cnt_nxt = r_edge_cnt;
        w_stop_ph_nxt  = r_stop_ph;
        w_baud_val_nxt = r_baud_val;
        w_frac_nxt     = r_frac;
        w_locked_nxt   = r_locked;

        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_nxt = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (w_fe) begin
                    w_state_nxt    = ST_MEASURE;
                    w_t_nxt        = '0;
                    w_seg_nxt      = '0;
                    w_edge_cnt_nxt = 3'd1;
                    w_stop_ph_nxt  = 1'b0;
                end
            end
            ST_MEASURE: begin
                if ((&r_t) || (&r_seg)) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_t_nxt   = w_t_inc;
                    w_seg_nxt = w_seg_inc;
                    if (w_fe) begin
                        w_seg_nxt      = '0;
                        w_edge_cnt_nxt = r_edge_cnt + 3'd1;
                        if (r_edge_cnt == 3'd1) begin
                            w_i1_nxt = w_seg_inc;
                        end else if (w_tol_fail) begin
                            w_state_nxt = ST_ERR;
                        end else if (r_edge_cnt == 3'(c_EDGES_PER_SYNC - 1)) begin
                            w_state_nxt = ST_STOP_CHK;
                        end
                    end
                end
            end
            ST_STOP_CHK: begin
                w_seg_nxt = w_seg_inc;
                if (!r_stop_ph) begin
                    // Wait for the rise that ends b7
                    if (w_seg_inc > w_stop_lim) begin
                        w_state_nxt = ST_ERR;
                    end else if (w_re) begin
                        w_seg_nxt     = '0;
                        w_stop_ph_nxt = 1'b1;
                    end
                end else begin
                    // Stop bit must stay high for half the two-bit interval
                    if (!w_rx_s) begin
                        w_state_nxt = ST_ERR;
                    end else if (w_seg_inc >= w_half) begin
                        w_state_nxt = w_range_ok ? ST_DONE : ST_ERR;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_WAIT_START;
            end
            ST_ERR: begin
                w_state_nxt = ST_WAIT_START;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Disable aborts everything silently
        if (!enable) w_state_nxt = ST_IDLE;

        if (w_state_nxt == ST_MEASURE && r_state == ST_WAIT_START) w_locked_nxt = 1'b0;
        if (w_state_nxt == ST_DONE) begin
            w_baud_val_nxt = w_bv;
            w_frac_nxt     = w_frac_calc;
            w_locked_nxt   = 1'b1;
        end

        w_err_nxt  = (w_state_nxt == ST_ERR);
        w_busy_nxt = (w_state_nxt == ST_MEASURE) || (w_state_nxt == ST_STOP_CHK);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_t        <= '0;
            r_seg      <= '0;
            r_i1       <= '0;
            r_edge_cnt <= 3'd0;
            r_stop_ph  <= 1'b0;
            r_baud_val <= 13'd0;
            r_frac     <= 3'd0;
            r_locked   <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_t        <= w_t_nxt;
            r_seg      <= w_seg_nxt;
            r_i1       <= w_i1_nxt;
            r_edge_cnt <= w_edge_cnt_nxt;
            r_stop_ph  <= w_stop_ph_nxt;
            r_baud_val <= w_baud_val_nxt;
            r_frac     <= w_frac_nxt;
            r_locked   <= w_locked_nxt;
            r_busy     <= w_busy_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign baud_val          = r_baud_val;
    assign baud_val_fraction = r_frac;
    assign locked            = r_locked;
    assign busy              = r_busy;
    assign detect_err        = r_err;

endmodule

`default_nettype wire
